// File: rtl/muxn_rr_if.sv
// muxn_rr_if: producer/consumer bundle for the N:1 round-robin mux
interface muxn_rr_if #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int SW = (N > 1 ? $clog2(N) : 1)
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           fixed_en;
    logic [SW-1:0]  fixed_sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_sel;

    modport master (
        output in_data, in_valid, fixed_en, fixed_sel, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );

    modport slave (
        input  in_data, in_valid, fixed_en, fixed_sel, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );
endinterface

// File: rtl/muxn_rr.sv
// muxn_rr: N:1 valid/ready mux, round-robin or fixed select, one registered output stage
module muxn_rr #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int SW = (N > 1 ? $clog2(N) : 1)
) (
    input  logic     clk,
    input  logic     rst_n,
    muxn_rr_if.slave bus
);
    logic          load;
    logic          gnt_v;
    logic [SW-1:0] gnt;
    logic [SW-1:0] idx;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;
    logic          out_valid_q, out_valid_d;

    assign load = !out_valid_q || bus.out_ready;

    // Grant: first valid channel at or after ptr (cyclic), or the forced channel when it is valid
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = SW'((int'(ptr_q) + k) % N);
            if (!bus.fixed_en && bus.in_valid[idx]) begin
                gnt_v = 1'b1;
                gnt   = idx;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.fixed_en && bus.fixed_sel == SW'(i) && bus.in_valid[i]) begin
                gnt_v = 1'b1;
                gnt   = SW'(i);
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_rdy
        assign bus.in_ready[i] = load && gnt_v && gnt == SW'(i);
    end

    // Next state: refill or empty the output register on load; pointer only moves in round-robin
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = gnt_v;
            if (gnt_v) begin
                out_data_d = bus.in_data[int'(gnt)*W +: W];
                out_sel_d  = gnt;
                if (!bus.fixed_en)
                    ptr_d = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
            end
        end
    end

    // State registers; reset drops any held beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_muxn_rr.sv
// tb_muxn_rr: scoreboard bench for muxn_rr with N=4 and N=3 instances
module tb_muxn_rr;
    logic clk = 1'b0;
    logic rst_n;
    int   pass_n = 0;
    int   total_n = 0;
    logic [15:0] d4 [4];
    logic [15:0] d3 [3];
    logic [17:0] q4 [$];
    logic [17:0] q3 [$];
    logic [17:0] e4, e3;

    muxn_rr_if #(.W(16), .N(4)) b4 ();
    muxn_rr_if #(.W(16), .N(3)) b3 ();

    muxn_rr #(.W(16), .N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    muxn_rr #(.W(16), .N(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor for the N=4 instance: every transferred beat must match the queue front
    always @(negedge clk) begin
        if (rst_n && b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) check("beat4_unexpected", 32'd1, 32'd0);
            else begin
                e4 = q4.pop_front();
                check("beat4_data", 32'(b4.out_data), 32'(e4[17:2]));
                check("beat4_sel", 32'(b4.out_sel), 32'(e4[1:0]));
            end
        end
    end

    // Monitor for the N=3 instance
    always @(negedge clk) begin
        if (rst_n && b3.out_valid && b3.out_ready) begin
            if (q3.size() == 0) check("beat3_unexpected", 32'd1, 32'd0);
            else begin
                e3 = q3.pop_front();
                check("beat3_data", 32'(b3.out_data), 32'(e3[17:2]));
                check("beat3_sel", 32'(b3.out_sel), 32'(e3[1:0]));
            end
        end
    end

    // Drive one cycle on one instance; g is the hand-computed granted channel or -1
    task automatic step(input bit n3, input logic [3:0] v, input logic rdy, input logic fen,
                        input logic [1:0] fs, input int g);
        logic [3:0] er;
        if (n3) begin
            b3.in_data   = {d3[2], d3[1], d3[0]};
            b3.in_valid  = v[2:0];
            b3.out_ready = rdy;
            b3.fixed_en  = fen;
            b3.fixed_sel = fs;
            if (g >= 0) q3.push_back({d3[g], 2'(g)});
        end else begin
            b4.in_data   = {d4[3], d4[2], d4[1], d4[0]};
            b4.in_valid  = v;
            b4.out_ready = rdy;
            b4.fixed_en  = fen;
            b4.fixed_sel = fs;
            if (g >= 0) q4.push_back({d4[g], 2'(g)});
        end
        er = (g >= 0) ? 4'(1 << g) : 4'd0;
        @(negedge clk);
        if (n3) check("in_ready3", 32'({1'b0, b3.in_ready}), 32'(er));
        else check("in_ready4", 32'(b4.in_ready), 32'(er));
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) d4[i] = 16'h00A0 + 16'(i);
        for (int i = 0; i < 3; i++) d3[i] = 16'h00B0 + 16'(i);
        b4.in_data = '0; b4.in_valid = '0; b4.out_ready = 1'b1; b4.fixed_en = 1'b0; b4.fixed_sel = '0;
        b3.in_data = '0; b3.in_valid = '0; b3.out_ready = 1'b1; b3.fixed_en = 1'b0; b3.fixed_sel = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid4", 32'(b4.out_valid), 32'd0);
        check("rst_valid3", 32'(b3.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // load a beat then reset asynchronously mid-cycle
        step(0, 4'hF, 1, 0, 0, 0);
        check("pre_rst_valid", 32'(b4.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(b4.out_valid), 32'd0);
        check("midrst_data", 32'(b4.out_data), 32'd0);
        check("midrst_sel", 32'(b4.out_sel), 32'd0);
        q4.delete();
        q3.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        // saturation: ptr restarts at 0 and cycles
        for (int k = 0; k < 6; k++) step(0, 4'hF, 1, 0, 0, k % 4);
        // backpressure: hold beat from channel 1
        for (int k = 0; k < 5; k++) begin
            step(0, 4'hF, 0, 0, 0, -1);
            check("bp_data", 32'(b4.out_data), 32'h00A1);
            check("bp_valid", 32'(b4.out_valid), 32'd1);
        end
        step(0, 4'hF, 1, 0, 0, 2);
        check("nobubble_sel", 32'(b4.out_sel), 32'd2);
        step(0, 4'hF, 1, 0, 0, 3);
        step(0, 4'hF, 1, 0, 0, 0);
        // fixed select on channel 2, ptr frozen at 1
        for (int k = 0; k < 3; k++) step(0, 4'b0101, 1, 1, 2, 2);
        step(0, 4'b0001, 1, 1, 2, -1);
        check("fixed_drop_valid", 32'(b4.out_valid), 32'd0);
        step(0, 4'hF, 1, 0, 0, 1);
        // idle then single pulse on channel 1
        step(0, 4'h0, 1, 0, 0, -1);
        check("idle_valid", 32'(b4.out_valid), 32'd0);
        check("idle_data_hold", 32'(b4.out_data), 32'h00A1);
        check("idle_sel_hold", 32'(b4.out_sel), 32'd1);
        for (int i = 0; i < 4; i++) d4[i] = 16'hFFFF;
        d4[1] = 16'h1234;
        step(0, 4'b0010, 1, 0, 0, 1);
        check("pulse_valid", 32'(b4.out_valid), 32'd1);
        check("pulse_data", 32'(b4.out_data), 32'h1234);
        step(0, 4'h0, 1, 0, 0, -1);
        // N=3: sparse grants and wrap from channel 2 to 0
        step(1, 4'b0010, 1, 0, 0, 1);
        step(1, 4'b0011, 1, 0, 0, 0);
        step(1, 4'b0011, 1, 0, 0, 1);
        step(1, 4'b0100, 1, 0, 0, 2);
        step(1, 4'b0111, 1, 0, 0, 0);
        // out-of-range fixed select never grants
        step(1, 4'b0111, 1, 1, 3, -1);
        check("oor_valid", 32'(b3.out_valid), 32'd0);
        check("oor_data", 32'(b3.out_data), 32'h00B0);
        check("oor_sel", 32'(b3.out_sel), 32'd0);
        step(1, 4'b0111, 1, 1, 2, 2);
        step(1, 4'b0111, 1, 0, 0, 1);
        step(1, 4'b0000, 1, 0, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        check("q4_empty", 32'(q4.size()), 32'd0);
        check("q3_empty", 32'(q3.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
